// File: rtl/irq_ctrl_module.sv
// Interrupt request controller: rising-edge latching of peripheral requests, enable mask,
// fixed lowest-index-first priority, and a single non-nesting request/service handshake.
module irq_ctrl_module #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_WD,
  input  logic               ACK,
  input  logic               EOI,
  output logic               IRQ,
  output logic [ID_W-1:0]    IRQ_ID,
  output logic               IN_SERVICE,
  output logic [NUM_SRC-1:0] PENDING,
  output logic [NUM_SRC-1:0] MASK
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SERV = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               id_load;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    win_id;

  assign src_edge = SRC_IRQ & ~prev_q;

  // Eligibility reads the registered mask, so a mask write in the same cycle
  // as an IDLE->REQ decision only takes effect from the next cycle on.
  assign eligible = PENDING & MASK;

  assign ack_clr = (state_q == S_REQ && ACK) ? (NUM_SRC'(1) << IRQ_ID) : '0;

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    id_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d = S_REQ;
          id_load = 1'b1;
        end
      end
      S_REQ:   if (ACK) state_d = S_SERV;
      S_SERV:  if (EOI) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      IRQ_ID  <= '0;
      prev_q  <= '0;
      PENDING <= '0;
      MASK    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= SRC_IRQ;
      if (id_load) IRQ_ID <= win_id;
      if (MASK_WE) MASK <= MASK_WD;
      // A new edge on the acknowledged source survives the clear.
      PENDING <= (PENDING & ~ack_clr) | src_edge;
    end
  end

  assign IRQ        = (state_q == S_REQ);
  assign IN_SERVICE = (state_q == S_SERV);

endmodule

// File: doc/irq_ctrl_module.md
# irq_ctrl_module

Interrupt request controller that produces the single `IRQ` line consumed by the control logic, which forces the trap opcode while `IRQ` is high. Latches rising edges from `NUM_SRC` peripheral sources, applies an enable mask, picks the highest-priority pending source and holds `IRQ`/`IRQ_ID` stable until the core acknowledges the trap. Tracks one in-service interrupt until the handler signals end-of-interrupt. No nesting.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 2..16.
- `ID_W`, 3: width of `IRQ_ID`; must equal clog2(`NUM_SRC`).

- `CLK`  in  1  system clock; all state changes on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `SRC_IRQ`  in  NUM_SRC  per-source request lines, rising-edge sensitive.
- `MASK_WE`  in  1  mask register write strobe.
- `MASK_WD`  in  NUM_SRC  mask write data; bit = 1 enables the source.
- `ACK`  in  1  core has taken the trap for the current `IRQ_ID`; one-cycle pulse.
- `EOI`  in  1  handler finished; one-cycle pulse.
- `IRQ`  out  1  interrupt request to the control logic.
- `IRQ_ID`  out  ID_W  index of the requested or in-service source.
- `IN_SERVICE`  out  1  a handler is active.
- `PENDING`  out  NUM_SRC  pending register, unmasked view.
- `MASK`  out  NUM_SRC  current mask register.

## Operation
- Edge detect: `prev` register samples `SRC_IRQ` every cycle. `edge = SRC_IRQ & ~prev`. `PENDING |= edge`. Levels held high produce no further pendings.
- Mask: `MASK <= MASK_WD` when `MASK_WE` is high. Masked sources still latch pending. They become eligible as soon as they are unmasked.
- Eligible set = `PENDING & MASK`. Priority is fixed, with the lowest index highest.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if eligible ≠ 0, go to REQ. Latch `IRQ_ID` = highest-priority eligible index.
  - REQ: `IRQ`=1. `IRQ_ID` is frozen; later higher-priority arrivals or mask changes do not alter it. `ACK`=1 moves to SERV, clears `PENDING[IRQ_ID]` and sets `IN_SERVICE`=1.
  - SERV: `IRQ`=0 and `IN_SERVICE`=1. `IRQ_ID` holds the serviced index. `EOI`=1 moves to IDLE and sets `IN_SERVICE`=0.
- `IRQ` and `IN_SERVICE` are registered and decoded from state only. No combinational path from any input to any output.
- Ignored events: `ACK` in IDLE or SERV, and `EOI` in IDLE or REQ. No state change.
- Simultaneous set and clear: a new edge on source `IRQ_ID` in the same cycle as `ACK` leaves `PENDING[IRQ_ID]`=1. Set wins, so the source is serviced again after EOI.
- Simultaneous `MASK_WE` and an IDLE→REQ decision: the decision uses the old `MASK`.
- Reset (any state, including REQ/SERV): state=IDLE, `IRQ`=0, `IRQ_ID`=0, `IN_SERVICE`=0, `PENDING`=0, `MASK`=0 (all disabled), `prev`=0. An in-flight request is discarded.
  - Because `prev` resets to 0, a source held high through reset registers one edge in the first cycle after reset.

## Timing
- `SRC_IRQ` rises before edge k → `PENDING` bit visible after edge k → `IRQ`=1 after edge k+1, provided the source is enabled and the FSM is in IDLE. Latency is 2 cycles.
- `ACK` sampled at edge m → `IRQ`=0 and `IN_SERVICE`=1 after edge m. `PENDING` bit clear after edge m.
- `EOI` sampled at edge e → IDLE after edge e. If another source is eligible, `IRQ`=1 after edge e+1; minimum one IRQ-low cycle between services.
- Unmasking a pending source at edge u → `IRQ`=1 after edge u+1 (from IDLE).
- `IRQ` remains high indefinitely until `ACK`. There is no timeout.

## Test plan
- Single source: `MASK`=0xFF. Pulse `SRC_IRQ[5]` at cycle 10. Expect `PENDING`=0x20 at cycle 11, then `IRQ`=1 and `IRQ_ID`=5 at 12. `ACK` at 15 gives `IRQ`=0, `IN_SERVICE`=1 and `PENDING`=0. `EOI` at 20 gives `IN_SERVICE`=0.
- Priority and freeze: raise sources 6 and 3 together, so `IRQ_ID`=3. While in REQ, raise source 0; `IRQ_ID` stays 3. After ACK and EOI, the next request has `IRQ_ID`=0, then 6.
- Masking: `MASK`=0x00, pulse source 2. Expect `PENDING`=0x04 and `IRQ` stays 0 for 20 cycles. Write `MASK`=0x04 at cycle u; expect `IRQ`=1 with `IRQ_ID`=2 at u+2.
- Set/clear collision: in REQ for source 4, a new edge on source 4 coincides with `ACK`. Expect `PENDING[4]`=1 after ACK. After EOI, `IRQ` reasserts with `IRQ_ID`=4.
- Spurious handshakes: `ACK` in IDLE and `EOI` in REQ cause no state or output change. A level held high on source 1 for 50 cycles yields exactly one service.
- Reset mid-operation: assert `RESET` in SERV and again in REQ. Next cycle, all outputs are 0 and `MASK`=0. A source high across reset produces `PENDING` bit set one cycle after reset release.
